// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the DPRAM stream reader: FSM encoding and the
// supported RAM read latency.
package dpram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SUPPORTED_LATENCY = 1;

endpackage

// File: rtl/dpram_stream_reader_fifo2.sv
// Two-entry registered FIFO with a valid/ready read side. The head register
// drives the output directly, so valid_o/data_o never depend on ready_i.
module stream_skid_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop = (count_q != 2'd0) && ready_i;

  // A write into a full FIFO without a pop is dropped; the writer must track credits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (wr_en_i) begin
          head_d  = wr_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (wr_en_i && pop) begin
          head_d = wr_data_i;
        end else if (wr_en_i) begin
          tail_d  = wr_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (wr_en_i) begin
            tail_d = wr_data_i;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Read engine for a simple dual-port RAM: streams len words starting at base
// out of a 1-cycle registered read port onto a valid/ready interface.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int WIDTHAD = 10,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic [WIDTHAD-1:0] base_in,
  input  logic [WIDTHAD:0]   len_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               rd_en_out,
  output logic [WIDTHAD-1:0] rd_addr_out,
  input  logic [WIDTH-1:0]   rd_data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               valid_out,
  input  logic               ready_in
);

  generate
    if (LATENCY != SUPPORTED_LATENCY) begin : g_latency_check
      $error("dpram_stream_reader: only LATENCY=1 is supported");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTHAD-1:0] base_q, base_d;
  logic [WIDTHAD:0]   len_q, len_d;
  logic [WIDTHAD:0]   issued_q, issued_d;
  logic [WIDTHAD:0]   delivered_q, delivered_d;
  logic               inflight_q, inflight_d;

  logic               rd_en;
  logic               fifo_valid;
  logic [1:0]         fifo_count;
  logic               transfer;
  logic [1:0]         occ_after;
  logic               credit_ok;

  assign transfer  = fifo_valid & ready_in;
  // A word leaving the buffer this cycle frees its slot for the read issued now.
  assign occ_after = fifo_count - {1'b0, transfer};
  assign credit_ok = (({1'b0, inflight_q} + occ_after) < 2'd2);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          base_d      = base_in;
          len_d       = len_in;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (len_in == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = (issued_q < len_q) && credit_ok;
        if (rd_en) begin
          issued_d = issued_q + 1'b1;
        end
        if (transfer) begin
          delivered_d = delivered_q + 1'b1;
          if (delivered_d == len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign inflight_d = rd_en;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
    end
  end

  stream_skid_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk_i    (clock_in),
    .rst_i    (reset_in),
    .wr_en_i  (inflight_q),
    .wr_data_i(rd_data_in),
    .valid_o  (fifo_valid),
    .data_o   (data_out),
    .ready_i  (ready_in),
    .count_o  (fifo_count)
  );

  assign busy_out    = (state_q != ST_IDLE);
  assign done_out    = (state_q == ST_DONE);
  assign rd_en_out   = rd_en;
  assign rd_addr_out = base_q + issued_q[WIDTHAD-1:0];
  assign valid_out   = fifo_valid;

endmodule
